// File: rtl/db_arbiter.sv
// db_arbiter: N-channel DataBus arbiter (round-robin or fixed priority) in front of one
// memory/MMU slave port, with slave-timeout bus error and abort on request withdrawal.
module db_arbiter #(
    parameter int NCH        = 2,
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int TIMEOUT    = 255,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              res,
    input  logic [NCH*AW-1:0] m_addr,
    input  logic [NCH*2-1:0]  m_accessType,
    input  logic [NCH*DW-1:0] m_dataOut,
    output logic [DW-1:0]     m_dataIn,
    output logic [NCH-1:0]    m_ready,
    output logic [NCH-1:0]    m_busErr,
    output logic [AW-1:0]     db_addr,
    output logic [1:0]        db_accessType,
    output logic [DW-1:0]     db_dataOut,
    input  logic [DW-1:0]     db_dataIn,
    input  logic              db_ready,
    output logic [NCH-1:0]    grant,
    output logic              busy
);
    localparam logic [1:0]    MEM_ACCESS_NONE = 2'b00;
    localparam int            IW       = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic          TMO_EN   = (TIMEOUT != 0) ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [NCH-1:0]  grant_r;
    logic [IW-1:0]   gidx_r;
    logic [IW-1:0]   last_r;
    logic [CW-1:0]   cnt_r;
    logic [NCH-1:0]  req_s;
    logic            sel_valid_s;
    logic [IW-1:0]   sel_idx_s;
    logic [IW-1:0]   scan_s;
    logic            greq_s;
    logic            tmo_s;

    // Per-channel request flags: anything other than NONE is a request
    always_comb begin
        req_s = '0;
        for (int i = 0; i < NCH; i++) begin
            req_s[i] = (m_accessType[i*2 +: 2] != MEM_ACCESS_NONE);
        end
    end

    // Winner selection: rotate from last+1 in round-robin mode, lowest index in fixed mode
    always_comb begin
        sel_valid_s = 1'b0;
        sel_idx_s   = '0;
        scan_s      = '0;
        for (int k = 0; k < NCH; k++) begin
            if (FIXED_PRIO) begin
                scan_s = IW'(k);
            end else begin
                scan_s = IW'((int'(last_r) + 1 + k) % NCH);
            end
            if (!sel_valid_s && req_s[scan_s]) begin
                sel_valid_s = 1'b1;
                sel_idx_s   = scan_s;
            end else begin
                sel_idx_s   = sel_idx_s;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; withdrawal, completion and timeout all return to idle
    always_comb begin
        greq_s      = req_s[gidx_r];
        tmo_s       = TMO_EN && (cnt_r == CNT_LAST);
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (sel_valid_s) begin
                    state_nxt_s = S_BUSY;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (!greq_s || db_ready || tmo_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_BUSY;
                end
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // Grant, round-robin pointer and saturating wait counter
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            grant_r <= '0;
            gidx_r  <= '0;
            last_r  <= IW'(NCH - 1);
            cnt_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (sel_valid_s) begin
                        grant_r <= NCH'(1'b1) << sel_idx_s;
                        gidx_r  <= sel_idx_s;
                        last_r  <= sel_idx_s;
                        cnt_r   <= '0;
                    end else begin
                        grant_r <= '0;
                    end
                end
                S_BUSY: begin
                    if (state_nxt_s == S_IDLE) begin
                        grant_r <= '0;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r   <= cnt_r + CW'(1'b1);
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                default: begin
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Outputs: slave port mirrors the granted master while busy
    always_comb begin
        m_dataIn      = db_dataIn;
        m_ready       = '0;
        m_busErr      = '0;
        db_addr       = '0;
        db_accessType = MEM_ACCESS_NONE;
        db_dataOut    = '0;
        grant         = grant_r;
        busy          = (state_r == S_BUSY);
        if (state_r == S_BUSY) begin
            db_addr       = m_addr[gidx_r*AW +: AW];
            db_accessType = m_accessType[gidx_r*2 +: 2];
            db_dataOut    = m_dataOut[gidx_r*DW +: DW];
            if (greq_s && db_ready) begin
                m_ready[gidx_r] = 1'b1;
            end else if (greq_s && tmo_s) begin
                m_busErr[gidx_r] = 1'b1;
                db_accessType    = MEM_ACCESS_NONE;
            end else begin
                m_ready = '0;
            end
        end else begin
            db_accessType = MEM_ACCESS_NONE;
        end
    end

endmodule

// File: doc/db_arbiter.md
Name: db_arbiter

Overview:
- Parametrised N-channel arbiter on the DataBus between several bus masters (CPU instruction fetch, CPU data, DMA) and a single memory/MMU slave port.
- Each channel uses the same handshake the CPU core drives:
  - addr and accessType are held until ready.
  - `MEM_ACCESS_NONE` means no request.
- Adds round-robin or fixed-priority selection, per-channel bus-error signalling on slave timeout, and clean abort when a master withdraws its request.

Parameters:
- NCH, 2, number of master channels (1..8).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles in S_BUSY without db_ready before a bus error; 0 disables the timeout.
- FIXED_PRIO, 0, arbitration mode: 0 = round-robin; 1 = fixed priority, channel 0 highest.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- res  in  1  asynchronous, active-low reset.
- m_addr  in  NCH*AW  per-channel address; channel i occupies bits [i*AW +: AW].
- m_accessType  in  NCH*2  per-channel access type (`MEM_ACCESS_NONE/R/W/X`, encodings from DataBus.vh).
- m_dataOut  in  NCH*DW  per-channel write data.
- m_dataIn  out  DW  read data; combinational copy of db_dataIn, broadcast to all channels.
- m_ready  out  NCH  per-channel transfer-complete strobe.
- m_busErr  out  NCH  per-channel one-cycle timeout error strobe.
- db_addr  out  AW  slave address.
- db_accessType  out  2  slave access type.
- db_dataOut  out  DW  slave write data.
- db_dataIn  in  DW  slave read data.
- db_ready  in  1  slave completion.
- grant  out  NCH  one-hot registered grant; all zero when idle.
- busy  out  1  high in S_BUSY.

Behaviour:
- Request definition: req[i] = (m_accessType[i] != `MEM_ACCESS_NONE`).
- Reset (res=0, asynchronous):
  - state = S_IDLE, grant = 0, last = NCH-1 (so channel 0 wins first round-robin), timeout counter = 0.
  - Outputs: db_accessType = NONE, db_addr = 0, db_dataOut = 0, m_ready = 0, m_busErr = 0, busy = 0.
- S_IDLE:
  - Slave outputs are driven NONE/0/0.
  - If any req, the selected channel is latched into grant, state goes to S_BUSY, counter is cleared.
  - Otherwise stay in S_IDLE.
- Selection:
  - Round-robin: first requesting channel scanning last+1, last+2, ... modulo NCH.
  - Fixed priority: lowest requesting index.
  - `last` is updated to the granted index when the grant is taken.
- S_BUSY with granted channel g:
  - db_addr, db_accessType and db_dataOut are combinational copies of channel g's inputs.
  - m_ready[g] = db_ready. All other m_ready bits are 0.
- S_BUSY exits, in priority order:
  1. req[g] = 0 (master withdrew): abort. Go to S_IDLE, no m_ready, no error.
  2. db_ready = 1: m_ready[g] pulses this cycle. Go to S_IDLE, grant = 0.
  3. TIMEOUT != 0 and counter == TIMEOUT-1: m_busErr[g] = 1 for this cycle. db_accessType is forced to NONE this cycle. Go to S_IDLE.
  4. Otherwise counter increments and state stays S_BUSY.
- Latency:
  - Grant is registered, so the slave sees a request 1 cycle after it appears.
  - A single zero-wait transfer therefore takes 2 cycles.
  - Back-to-back transfers from one master take 2 cycles each. The S_IDLE gap after every completion is mandatory.
- Simultaneous events:
  - db_ready in the timeout cycle counts as completion; no error.
  - New requests arriving during S_BUSY wait; they are never dropped or reordered.
- Reset mid-transfer: immediate return to S_IDLE; the slave sees NONE asynchronously.
- Width rules:
  - Counter width is clog2(TIMEOUT+1). It saturates and never wraps.
  - NCH=1 degenerates to a pass-through with one idle cycle per transfer.
- grant is always one-hot or zero; never multi-hot.

Test Plan:
- Reset/idle: res=0 then 1, no requests, 10 cycles -> grant=0, db_accessType=NONE, busy=0 throughout.
- Single read: ch0 R at addr 0x0000_0100; slave ready on 3rd BUSY cycle with db_dataIn=0xDEADBEEF -> grant=01 one cycle after request; m_ready[0] high exactly 1 cycle; m_dataIn=0xDEADBEEF; return to IDLE.
- Round-robin contention: ch0 X and ch1 W requesting continuously, zero-wait slave -> grant order 01,10,01,10…; each channel completes every 4 cycles.
- Fixed priority (FIXED_PRIO=1): same stimulus -> ch0 granted every time; ch1 granted only after ch0 drops to NONE.
- Timeout (TIMEOUT=4): ch1 R, db_ready never asserted -> m_busErr[1] pulses on the 4th BUSY cycle; no m_ready; IDLE next cycle.
- Abort/reset: ch0 W granted, master drives NONE on 2nd BUSY cycle -> IDLE next cycle, no strobes. Repeat with res=0 mid-BUSY -> db_accessType=NONE immediately.
